// File: rtl/trn_agc_pkg.sv
// Shared types and constants for the TRN_AGC AXI4-Lite register bank.
package trn_agc_pkg;

  localparam int AGC_REG_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  // Word index of a byte address: keep the low addr_w bits, drop the byte offset.
  function automatic int unsigned addr_to_idx(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return (addr & mask) >> 2;
  endfunction

endpackage

// File: rtl/trn_agc_strb_reg.sv
// 32-bit register with per-byte write enables and an asynchronous reset value.
module trn_agc_strb_reg
  import trn_agc_pkg::*;
#(
  parameter logic [AGC_REG_W-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AGC_REG_W/8-1:0] strb,
  input  logic [AGC_REG_W-1:0]   d,
  output logic [AGC_REG_W-1:0]   q
);

  logic [7:0] byte_reg [AGC_REG_W/8];

  generate
    for (genvar gi = 0; gi < AGC_REG_W/8; gi++) begin : g_byte
      // Each byte lane updates only when its strobe is set during a write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          byte_reg[gi] <= RESET_VAL[8*gi +: 8];
        end else if (we && strb[gi]) begin
          byte_reg[gi] <= d[8*gi +: 8];
        end
      end
      assign q[8*gi +: 8] = byte_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/trn_agc_s_axi_regs.sv
// AXI4-Lite slave register bank for TRN_AGC: independent write and read
// FSMs, one transaction of each kind outstanding, flat register outputs and
// a one-cycle write pulse per register.
module trn_agc_s_axi_regs
  import trn_agc_pkg::*;
#(
  parameter int          C_S00_AXI_DATA_WIDTH = 32,
  parameter int          C_S00_AXI_ADDR_WIDTH = 4,
  parameter int          NUM_REGS             = 4,
  parameter logic [31:0] REG_RESET            = 32'h0000_0000
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [NUM_REGS*AGC_REG_W-1:0]     reg_out,
  output logic [NUM_REGS-1:0]               reg_wr_pulse
);

  localparam int AW = C_S00_AXI_ADDR_WIDTH;

  // Protection bits carry no meaning for this register bank.
  logic unused_prot;
  assign unused_prot = ^{s00_axi_awprot, s00_axi_arprot};

  // ---------------- write channel ----------------
  wr_state_t              wr_state_reg, wr_state_next;
  logic [AW-1:0]          aw_addr_reg;
  logic [AGC_REG_W-1:0]   w_data_reg;
  logic [AGC_REG_W/8-1:0] w_strb_reg;
  logic [1:0]             bresp_reg;
  logic [NUM_REGS-1:0]    pulse_reg;

  logic                   commit, latch_aw, latch_w;
  logic [AW-1:0]          commit_addr;
  logic [AGC_REG_W-1:0]   commit_data;
  logic [AGC_REG_W/8-1:0] commit_strb;
  int unsigned            wr_idx;
  logic                   wr_idx_ok;
  logic [NUM_REGS-1:0]    reg_we;
  logic [AGC_REG_W-1:0]   reg_q [NUM_REGS];

  // Write FSM: readies/bvalid decoded from state; commit uses whichever of
  // addr/data is live on the bus versus already latched.
  always_comb begin
    wr_state_next   = wr_state_reg;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    commit          = 1'b0;
    latch_aw        = 1'b0;
    latch_w         = 1'b0;
    commit_addr     = aw_addr_reg;
    commit_data     = w_data_reg;
    commit_strb     = w_strb_reg;
    case (wr_state_reg)
      W_IDLE: begin
        s00_axi_awready = 1'b1;
        s00_axi_wready  = 1'b1;
        commit_addr     = s00_axi_awaddr;
        commit_data     = s00_axi_wdata;
        commit_strb     = s00_axi_wstrb;
        if (s00_axi_awvalid && s00_axi_wvalid) begin
          commit        = 1'b1;
          wr_state_next = W_RESP;
        end else if (s00_axi_awvalid) begin
          latch_aw      = 1'b1;
          wr_state_next = W_HAVE_A;
        end else if (s00_axi_wvalid) begin
          latch_w       = 1'b1;
          wr_state_next = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        s00_axi_wready = 1'b1;
        commit_data    = s00_axi_wdata;
        commit_strb    = s00_axi_wstrb;
        if (s00_axi_wvalid) begin
          commit        = 1'b1;
          wr_state_next = W_RESP;
        end
      end
      W_HAVE_D: begin
        s00_axi_awready = 1'b1;
        commit_addr     = s00_axi_awaddr;
        if (s00_axi_awvalid) begin
          commit        = 1'b1;
          wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  assign wr_idx    = addr_to_idx(32'(commit_addr), AW);
  assign wr_idx_ok = (wr_idx < 32'(NUM_REGS));

  // Write state register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) wr_state_reg <= W_IDLE;
    else                  wr_state_reg <= wr_state_next;
  end

  // Holding registers for a half-arrived write, the response code and pulses.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bresp_reg   <= RESP_OKAY;
      pulse_reg   <= '0;
    end else begin
      if (latch_aw) aw_addr_reg <= s00_axi_awaddr;
      if (latch_w) begin
        w_data_reg <= s00_axi_wdata;
        w_strb_reg <= s00_axi_wstrb;
      end
      if (commit) bresp_reg <= wr_idx_ok ? RESP_OKAY : RESP_SLVERR;
      pulse_reg <= reg_we;
    end
  end

  assign s00_axi_bresp = bresp_reg;
  assign reg_wr_pulse  = pulse_reg;

  // ---------------- register file ----------------
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // An out-of-range index never matches, so such writes are dropped.
      assign reg_we[gi] = commit && (wr_idx == gi);

      trn_agc_strb_reg #(
        .RESET_VAL (REG_RESET)
      ) u_reg (
        .clk   (s00_axi_aclk),
        .rst_n (s00_axi_aresetn),
        .we    (reg_we[gi]),
        .strb  (commit_strb),
        .d     (commit_data),
        .q     (reg_q[gi])
      );

      assign reg_out[AGC_REG_W*gi +: AGC_REG_W] = reg_q[gi];
    end
  endgenerate

  // ---------------- read channel ----------------
  rd_state_t            rd_state_reg, rd_state_next;
  logic [AGC_REG_W-1:0] rdata_reg;
  logic [1:0]           rresp_reg;
  logic                 rd_accept;
  int unsigned          rd_idx;
  logic [AGC_REG_W-1:0] rd_chain [NUM_REGS+1];

  assign rd_idx      = addr_to_idx(32'(s00_axi_araddr), AW);
  assign rd_chain[0] = '0;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rd_mux
      assign rd_chain[gi+1] = rd_chain[gi] | ((rd_idx == gi) ? reg_q[gi] : '0);
    end
  endgenerate

  // Read FSM: accept in idle, hold the response until rready.
  always_comb begin
    rd_state_next   = rd_state_reg;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    rd_accept       = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        s00_axi_arready = 1'b1;
        if (s00_axi_arvalid) begin
          rd_accept     = 1'b1;
          rd_state_next = R_RESP;
        end
      end
      R_RESP: begin
        s00_axi_rvalid = 1'b1;
        if (s00_axi_rready) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Read state register plus the captured data/response (pre-write contents).
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rd_state_reg <= R_IDLE;
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
    end else begin
      rd_state_reg <= rd_state_next;
      if (rd_accept) begin
        rdata_reg <= rd_chain[NUM_REGS];
        rresp_reg <= (rd_idx < 32'(NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s00_axi_rdata = rdata_reg;
  assign s00_axi_rresp = rresp_reg;

endmodule

// File: doc/trn_agc_s_axi_regs.md
Name: trn_agc_s_axi_regs

Overview:
AXI4-Lite slave register bank for the TRN_AGC IP. It is the responder side of the S00_AXI control port that the VIP master drives. It terminates write/read transactions and holds the AGC control registers, exposed as flat outputs to the AGC datapath. It also produces a one-cycle write pulse per register so the datapath can react to updates.

Parameters:
C_S00_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S00_AXI_ADDR_WIDTH, 4, byte address width; register index = addr[ADDR_WIDTH-1:2].
NUM_REGS, 4, implemented registers, 1..2^(ADDR_WIDTH-2).
REG_RESET, 32'h0000_0000, reset value of every register.

Ports:
s00_axi_aclk  in  1  single clock.
s00_axi_aresetn  in  1  asynchronous active-low reset.
s00_axi_awaddr  in  ADDR_WIDTH  write address.
s00_axi_awprot  in  3  ignored.
s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake.
s00_axi_wdata  in  32  write data.
s00_axi_wstrb  in  4  byte enables.
s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake.
s00_axi_bresp  out  2  write response.
s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake.
s00_axi_araddr  in  ADDR_WIDTH  read address.
s00_axi_arprot  in  3  ignored.
s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake.
s00_axi_rdata  out  32  read data.
s00_axi_rresp  out  2  read response.
s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake.
reg_out  out  NUM_REGS*32  register contents; reg i at [32i+31:32i].
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after reg i commits.

Behaviour:
- Reset (async assert, sync release):
  - all registers = REG_RESET.
  - bvalid, rvalid, reg_wr_pulse = 0; bresp, rresp, rdata = 0.
  - awready, wready, arready = 1; both FSMs return to idle.
  - Reset mid-transaction drops any pending response silently.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP. Ready outputs are decoded from the state register only.
  - awready = 1 in W_IDLE and W_HAVE_D; wready = 1 in W_IDLE and W_HAVE_A; both 0 in W_RESP.
  - W_IDLE: AW only -> latch addr, go W_HAVE_A. W only -> latch data/strb, go W_HAVE_D. Both in the same cycle -> commit, go W_RESP.
  - W_HAVE_A + wvalid -> commit, go W_RESP. W_HAVE_D + awvalid -> commit, go W_RESP.
  - Commit: at the accepting edge, each byte lane with wstrb=1 is updated and the others are kept. bvalid rises from that edge. reg_wr_pulse[idx] is high for exactly the following cycle.
  - W_RESP: hold bvalid/bresp until bready is sampled high, then go to W_IDLE. No new AW/W accepted while in W_RESP; one write outstanding.
  - Best-case write latency: AW+W accepted at edge N, bvalid visible after N, W_IDLE after edge N+1 if bready is held high.
- Read FSM states: R_IDLE, R_RESP.
  - arready = 1 only in R_IDLE.
  - On arvalid, rdata is registered from the current register contents at that edge, and rvalid rises.
  - Hold rdata/rvalid/rresp until rready, then return to R_IDLE. One read outstanding.
- Read/write concurrency:
  - The two FSMs are independent.
  - A read accepted on the same edge as a write commit to the same index returns the old value.
- Address decode:
  - idx = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
  - idx >= NUM_REGS: write is discarded, no pulse, bresp = SLVERR (2'b10). Read returns rdata = 0, rresp = SLVERR.
  - Otherwise resp = OKAY (2'b00).
- wstrb = 0 to a valid index: handshake completes OKAY, contents unchanged, pulse still asserted.
- Response outputs hold stable while valid is high and ready is low.

Decomposition:
- Package trn_agc_pkg:
  - wr_state_t and rd_state_t enums.
  - constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - AGC_REG_W = 32.
  - function addr_to_idx.
- One sub-module: trn_agc_strb_reg, a 32-bit register with byte-strobe write enable and async reset value. It is instantiated NUM_REGS times with a generate loop.

Test Plan:
1. Reset release, then write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with wstrb=F, then read back -> reads return 0x1..0x4 with RRESP=OKAY; reg_wr_pulse pulses once per write on bits 0..3 in order.
2. AW 0x4 driven 3 cycles before W 0xDEADBEEF, then repeat with W 3 cycles before AW -> both complete with BRESP=OKAY and reg1=0xDEADBEEF. awready/wready drop correctly in W_HAVE_A/W_HAVE_D.
3. reg2=0x11223344, then write 0xAABBCCDD with wstrb=4'b0101 -> reg2=0x11BB33DD.
4. bready held low 10 cycles after a write, with rready held low 10 cycles on a read -> bvalid/bresp and rvalid/rdata are stable throughout; the next AW/AR is not accepted until each response handshake completes.
5. NUM_REGS=3, write 0x55 to 0xC and read 0xC -> BRESP=SLVERR, RRESP=SLVERR, rdata=0; no reg_wr_pulse; regs 0..2 unchanged.
6. Assert s00_axi_aresetn low mid-cycle while bvalid=1 and reg0=0x1234 -> bvalid, rvalid, reg_out = 0 immediately without waiting for a clock edge; a fresh write after release completes normally.
